wm_controller: RTL and testbench

Washing-machine sequencing controller. It tracks a coin-operated wash cycle (soak, wash, rinse, spin) from single-bit sensor and timer inputs. It handles lid-open and out-of-balance pauses, user cancel and motor faults. It sits between the front-panel/sensor logic and the actuator drivers, which decode its 3-bit `state` output.

---
 rtl/wm_pkg.sv | 28 ++
 rtl/wm_controller.sv | 90 +++++++++
 tb/tb_wm_controller.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller: the state encoding
// that the actuator drivers decode, and the phase-advance helper.
package wm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_SOAK  = 3'd2,
    ST_WASH  = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_PAUSE = 3'd6,
    ST_FAULT = 3'd7
  } wm_state_e;

  // Phase that follows a timer expiry; SPIN completes the cycle back to IDLE.
  function automatic wm_state_e next_phase(input wm_state_e cur);
    case (cur)
      ST_SOAK:  next_phase = ST_WASH;
      ST_WASH:  next_phase = ST_RINSE;
      ST_RINSE: next_phase = ST_SPIN;
      default:  next_phase = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wm_controller.sv
// Wash-cycle sequencer: coin/lid start, timed phases, lid and imbalance
// pauses with a resume target, cancel-to-spin and a sticky motor fault.
module wm_controller
  import wm_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sig_Lid_Closed,
  input  logic               sig_Coin,
  input  logic               sig_Cancel,
  input  logic               sig_Time_Out,
  input  logic               sig_Out_Of_Balance,
  input  logic               sig_Motor_Failure,
  output logic [STATE_W-1:0] state
);

  wm_state_e r_state;
  wm_state_e r_resume;
  wm_state_e w_next_state;
  wm_state_e w_next_resume;
  logic      w_lid_open;

  assign w_lid_open = ~sig_Lid_Closed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_resume <= ST_SOAK;
    end else begin
      r_state  <= w_next_state;
      r_resume <= w_next_resume;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_resume = r_resume;
    case (r_state)
      ST_IDLE: begin
        if (sig_Coin) w_next_state = ST_READY;
      end
      ST_READY: begin
        if (sig_Cancel)          w_next_state = ST_IDLE;
        else if (sig_Lid_Closed) w_next_state = ST_SOAK;
      end
      ST_SOAK, ST_WASH, ST_RINSE: begin
        // Imbalance only matters while the drum spins fast.
        if (sig_Motor_Failure) begin
          w_next_state = ST_FAULT;
        end else if (sig_Cancel) begin
          w_next_state = ST_SPIN;
        end else if (w_lid_open) begin
          w_next_state  = ST_PAUSE;
          w_next_resume = r_state;
        end else if (sig_Time_Out) begin
          w_next_state = next_phase(r_state);
        end
      end
      ST_SPIN: begin
        if (sig_Motor_Failure) begin
          w_next_state = ST_FAULT;
        end else if (w_lid_open || sig_Out_Of_Balance) begin
          w_next_state  = ST_PAUSE;
          w_next_resume = ST_SPIN;
        end else if (sig_Time_Out) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        // Cancel while paused redirects the resume to drain-and-spin.
        if (sig_Motor_Failure) begin
          w_next_state = ST_FAULT;
        end else if (sig_Cancel) begin
          w_next_resume = ST_SPIN;
        end else if (sig_Lid_Closed && !sig_Out_Of_Balance) begin
          w_next_state = r_resume;
        end
      end
      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_wm_controller.sv
// Self-checking bench for wm_controller: directed scenarios plus randomized
// stimulus compared against a rule-level model of the wash cycle.
module tb_wm_controller;

  logic       clock;
  logic       reset_n;
  logic       sig_Lid_Closed;
  logic       sig_Coin;
  logic       sig_Cancel;
  logic       sig_Time_Out;
  logic       sig_Out_Of_Balance;
  logic       sig_Motor_Failure;
  logic [2:0] state;

  int n_checks;
  int n_pass;

  // Reference model: plain integers, 0..7 as in the state table.
  int m_state;
  int m_resume;

  wm_controller dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .sig_Lid_Closed     (sig_Lid_Closed),
    .sig_Coin           (sig_Coin),
    .sig_Cancel         (sig_Cancel),
    .sig_Time_Out       (sig_Time_Out),
    .sig_Out_Of_Balance (sig_Out_Of_Balance),
    .sig_Motor_Failure  (sig_Motor_Failure),
    .state              (state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic model_step(input bit lid, input bit coin, input bit cancel,
                            input bit tout, input bit oob, input bit mf);
    bit running;
    running = (m_state >= 2 && m_state <= 6);
    if (m_state == 7) return;
    if (mf && running) begin
      m_state = 7;
      return;
    end
    if (m_state == 0) begin
      if (coin) m_state = 1;
      return;
    end
    if (m_state == 1) begin
      if (cancel) m_state = 0;
      else if (lid) m_state = 2;
      return;
    end
    if (m_state == 6) begin
      if (cancel) m_resume = 5;
      else if (lid && !oob) m_state = m_resume;
      return;
    end
    if (cancel && m_state != 5) begin
      m_state = 5;
      return;
    end
    if (!lid || (oob && m_state == 5)) begin
      m_resume = m_state;
      m_state  = 6;
      return;
    end
    if (tout) m_state = (m_state == 5) ? 0 : m_state + 1;
  endtask

  // Driver: apply inputs just after an edge, predict, advance one edge.
  task automatic drive(input bit lid, input bit coin, input bit cancel,
                       input bit tout, input bit oob, input bit mf);
    sig_Lid_Closed     = lid;
    sig_Coin           = coin;
    sig_Cancel         = cancel;
    sig_Time_Out       = tout;
    sig_Out_Of_Balance = oob;
    sig_Motor_Failure  = mf;
    model_step(lid, coin, cancel, tout, oob, mf);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    sig_Lid_Closed     = 1'b0;
    sig_Coin           = 1'b0;
    sig_Cancel         = 1'b0;
    sig_Time_Out       = 1'b0;
    sig_Out_Of_Balance = 1'b0;
    sig_Motor_Failure  = 1'b0;
    reset_n  = 1'b0;
    m_state  = 0;
    m_resume = 2;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // From IDLE, start a cycle and advance with timer pulses to the phase.
  task automatic goto_phase(input int target);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int p = 2; p < target; p++) drive(1, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_initial: state=%0d expected 0", state);
    else n_pass++;
    goto_phase(3);
    n_checks++;
    if (state !== 3'd3) $display("FAIL reset_reach_wash: state=%0d expected 3", state);
    else n_pass++;
    #2;
    reset_n  = 1'b0;
    m_state  = 0;
    m_resume = 2;
    #1;
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_async: state=%0d expected 0", state);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    sig_Coin = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_hold_idle: state=%0d expected 0", state);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int exp_seq[4];
    int bad;
    exp_seq = '{3, 4, 5, 0};
    apply_reset();
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd1) $display("FAIL nominal_ready: state=%0d expected 1", state);
    else n_pass++;
    drive(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd2) $display("FAIL nominal_soak: state=%0d expected 2", state);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      if (state !== 3'd2) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL nominal_soak_hold: %0d of 20 cycles left SOAK, last state=%0d expected 2", bad, state);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 0);
      n_checks++;
      if (state !== 3'(exp_seq[i]))
        $display("FAIL nominal_phase%0d: state=%0d expected %0d", i, state, exp_seq[i]);
      else n_pass++;
      drive(1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_pause_resume();
    apply_reset();
    goto_phase(3);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL pause_lid_open: state=%0d expected 6", state);
    else n_pass++;
    drive(0, 0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL pause_timeout_ignored: state=%0d expected 6", state);
    else n_pass++;
    drive(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd3) $display("FAIL pause_resume_wash: state=%0d expected 3", state);
    else n_pass++;
    drive(0, 0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL pause_lid_beats_timeout: state=%0d expected 6", state);
    else n_pass++;
    drive(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd3) $display("FAIL pause_resume_not_advanced: state=%0d expected 3", state);
    else n_pass++;
  endtask

  task automatic test_spin_imbalance();
    apply_reset();
    goto_phase(5);
    drive(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL spin_imbalance_pause: state=%0d expected 6", state);
    else n_pass++;
    drive(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL spin_imbalance_hold: state=%0d expected 6", state);
    else n_pass++;
    drive(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd5) $display("FAIL spin_resume: state=%0d expected 5", state);
    else n_pass++;
    drive(1, 0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd5) $display("FAIL spin_cancel_ignored: state=%0d expected 5", state);
    else n_pass++;
    drive(1, 0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd0) $display("FAIL spin_complete: state=%0d expected 0", state);
    else n_pass++;
  endtask

  task automatic test_cancel();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd0) $display("FAIL cancel_ready: state=%0d expected 0", state);
    else n_pass++;
    goto_phase(2);
    drive(1, 0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd5) $display("FAIL cancel_soak: state=%0d expected 5", state);
    else n_pass++;
    drive(1, 0, 0, 1, 0, 0);
    goto_phase(4);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd6) $display("FAIL cancel_in_pause_hold: state=%0d expected 6", state);
    else n_pass++;
    drive(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd5) $display("FAIL cancel_pause_to_spin: state=%0d expected 5", state);
    else n_pass++;
  endtask

  task automatic test_fault();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1);
    n_checks++;
    if (state !== 3'd0) $display("FAIL fault_idle_ignored: state=%0d expected 0", state);
    else n_pass++;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (state !== 3'd1) $display("FAIL fault_ready_ignored: state=%0d expected 1", state);
    else n_pass++;
    drive(0, 0, 1, 0, 0, 0);
    goto_phase(4);
    drive(0, 0, 1, 1, 1, 1);
    n_checks++;
    if (state !== 3'd7) $display("FAIL fault_rinse: state=%0d expected 7", state);
    else n_pass++;
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd7) $display("FAIL fault_sticky: state=%0d expected 7", state);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (state !== 3'd0) $display("FAIL fault_reset_clear: state=%0d expected 0", state);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bit lid, coin, cancel, tout, oob, mf;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) apply_reset();
      lid    = ($urandom_range(0, 9) != 0);
      coin   = ($urandom_range(0, 3) == 0);
      cancel = ($urandom_range(0, 19) == 0);
      tout   = ($urandom_range(0, 4) == 0);
      oob    = ($urandom_range(0, 14) == 0);
      mf     = ($urandom_range(0, 149) == 0);
      drive(lid, coin, cancel, tout, oob, mf);
      n_checks++;
      if (state !== 3'(m_state)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_step%0d: state=%0d expected %0d", i, state, m_state);
      end else begin
        n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    test_reset();
    test_nominal();
    test_pause_resume();
    test_spin_imbalance();
    test_cancel();
    test_fault();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
